// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator.
//   stateT  : FSM state encoding (IDLE, RUN, DONE).
//   resultT : packed result flags {eq, gt, lt}, with one-hot constants.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   typedef struct packed {
      logic eq;
      logic gt;
      logic lt;
   } resultT;

   localparam resultT RES_NONE = 3'b000;
   localparam resultT RES_EQ   = 3'b100;
   localparam resultT RES_GT   = 3'b010;
   localparam resultT RES_LT   = 3'b001;

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned comparator for one CHUNK-wide slice.
// Ports:
//   a, b : CHUNK-bit operand slices
//   eq   : a == b
//   gt   : a >  b (unsigned); "less than" is !eq && !gt
module cmp_chunk #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             eq,
   output logic             gt
);

   assign eq = (a == b);
   assign gt = (a > b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator. Compares two WIDTH-bit operands MSB-first,
// CHUNK bits per clock, stopping at the first differing chunk. Signed mode
// flips the sign bit of both operands at acceptance so the walk is always an
// unsigned compare.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request a compare (accepted in IDLE or DONE only)
//   signed_mode  : 1 = two's-complement, 0 = unsigned (sampled with start)
//   a, b         : operands (sampled with start)
//   busy         : compare in progress
//   done         : one-cycle pulse when the result becomes valid
//   a_eq_b, a_gt_b, a_lt_b : result flags, held until the next accepted start
//   chunks_used  : chunks examined for the last result
module seq_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic                                 signed_mode,
   input  logic [WIDTH-1:0]                     a,
   input  logic [WIDTH-1:0]                     b,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 a_eq_b,
   output logic                                 a_gt_b,
   output logic                                 a_lt_b,
   output logic [$clog2(WIDTH/CHUNK+1)-1:0]     chunks_used
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CUW    = $clog2(NCHUNK + 1);

   stateT            state, stateNext;
   logic [WIDTH-1:0] opA, opANext;
   logic [WIDTH-1:0] opB, opBNext;
   logic [IDXW-1:0]  idx, idxNext;
   logic [CUW-1:0]   chunksUsed, chunksUsedNext;
   resultT           res, resNext;

   logic [CHUNK-1:0] chunkA, chunkB;
   logic             chunkEq, chunkGt;

   // Select the current chunk with constant part-selects so the index never
   // has to be widened into a variable bit offset.
   always_comb begin
      chunkA = '0;
      chunkB = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IDXW'(i)) begin
            chunkA = opA[i*CHUNK +: CHUNK];
            chunkB = opB[i*CHUNK +: CHUNK];
         end
      end
   end

   cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
      .a  (chunkA),
      .b  (chunkB),
      .eq (chunkEq),
      .gt (chunkGt)
   );

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      stateNext      = state;
      opANext        = opA;
      opBNext        = opB;
      idxNext        = idx;
      chunksUsedNext = chunksUsed;
      resNext        = res;

      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               // Inverting the sign bit maps two's-complement order onto
               // unsigned order.
               opANext        = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
               opBNext        = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
               idxNext        = IDXW'(NCHUNK - 1);
               chunksUsedNext = '0;
               resNext        = RES_NONE;
               stateNext      = RUN;
            end else begin
               stateNext = IDLE;
            end
         end
         RUN: begin
            chunksUsedNext = chunksUsed + CUW'(1);
            if (!chunkEq) begin
               resNext   = chunkGt ? RES_GT : RES_LT;
               stateNext = DONE;
            end else if (idx == '0) begin
               resNext   = RES_EQ;
               stateNext = DONE;
            end else begin
               idxNext = idx - IDXW'(1);
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order. The operand
   // registers are ordinary flops (not a memory array), so they are reset too.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         opA        <= '0;
         opB        <= '0;
         idx        <= '0;
         chunksUsed <= '0;
         res        <= RES_NONE;
      end else begin
         state      <= stateNext;
         opA        <= opANext;
         opB        <= opBNext;
         idx        <= idxNext;
         chunksUsed <= chunksUsedNext;
         res        <= resNext;
      end
   end

   // Straight decodes of registered state; no combinational path from inputs.
   assign busy        = (state == RUN);
   assign done        = (state == DONE);
   assign a_eq_b      = res.eq;
   assign a_gt_b      = res.gt;
   assign a_lt_b      = res.lt;
   assign chunks_used = chunksUsed;

endmodule
